// File: rtl/sdc_arb_pkg.sv
// rtl/sdc_arb_pkg.sv - shared types and defaults for the SD-card block interface arbiter
package sdc_arb_pkg;

    localparam int SDC_ARB_NREQ    = 4;
    localparam int SDC_ARB_OWNER_W = $clog2(SDC_ARB_NREQ);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT,
        XFER
    } arb_state_e;

endpackage

// File: rtl/sdc_rr_picker.sv
// rtl/sdc_rr_picker.sv - combinational round-robin picker, search starts one past last_owner
module sdc_rr_picker
    import sdc_arb_pkg::*;
#(
    parameter int NREQ    = SDC_ARB_NREQ,
    parameter int OWNER_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]    pending_i,
    input  logic [OWNER_W-1:0] last_owner_i,
    output logic               valid_o,
    output logic [OWNER_W-1:0] winner_o
);

    int idx;

    // Walk farthest-first so the nearest pending requester is the final assignment.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_owner_i) + k) % NREQ;
            if (pending_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = OWNER_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sdc_arbiter.sv
// rtl/sdc_arbiter.sv - one-owner-at-a-time arbiter for the shared SD-card block interface
// Optional busy-start watchdog in WAIT is built when SDC_ARB_TIMEOUT_EN is defined.
module sdc_arbiter
    import sdc_arb_pkg::*;
#(
    parameter int          NREQ           = SDC_ARB_NREQ,
    parameter int          OWNER_W        = $clog2(NREQ),
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1048576
) (
    input  logic                 clk,
    input  logic                 _reset,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*32-1:0]   req_lba,
    input  logic [NREQ*8-1:0]    req_dout,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_err,
    output logic [31:0]          sdc_lba,
    output logic [NREQ-1:0]      sdc_rd,
    output logic [NREQ-1:0]      sdc_wr,
    output logic [7:0]           sdc_data_out,
    input  logic                 sdc_busy,
    input  logic                 sdc_done,
    output logic [OWNER_W-1:0]   owner
);

    arb_state_e          state_q, state_d;
    logic [NREQ-1:0]     pend_q;
    logic [NREQ-1:0]     dir_q;
    logic [31:0]         lba_q [NREQ];
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [OWNER_W-1:0]  last_q, last_d;
    logic [31:0]         sdc_lba_q;
    logic                done_flag_q;
    logic [NREQ-1:0]     req_done_q, done_d;
    logic [NREQ-1:0]     req_err_q, err_d;
    logic                pick_valid;
    logic [OWNER_W-1:0]  pick_winner;
    logic [NREQ-1:0]     owner_oh;

    sdc_rr_picker #(.NREQ(NREQ), .OWNER_W(OWNER_W)) u_picker (
        .pending_i    (pend_q),
        .last_owner_i (last_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    assign owner_oh = NREQ'(1) << owner_q;

`ifdef SDC_ARB_TIMEOUT_EN
    logic [23:0] wait_cnt_q;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT && state_d == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 24'd1;
        end else begin
            wait_cnt_q <= '0;
        end
    end
`else
    logic [23:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = SETUP;
                    owner_d = pick_winner;
                end
            end
            SETUP: state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (sdc_busy) begin
                    state_d = XFER;
                end
`ifdef SDC_ARB_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_CYCLES - 24'd1) begin
                    done_d  = owner_oh;
                    err_d   = owner_oh;
                    last_d  = owner_q;
                    state_d = IDLE;
                end
`endif
            end
            XFER: begin
                if (!sdc_busy) begin
                    done_d  = owner_oh;
                    err_d   = done_flag_q ? '0 : owner_oh;
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            dir_q       <= '0;
            owner_q     <= '0;
            last_q      <= OWNER_W'(NREQ - 1);
            sdc_lba_q   <= '0;
            done_flag_q <= 1'b0;
            req_done_q  <= '0;
            req_err_q   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                lba_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            req_done_q <= done_d;
            req_err_q  <= err_d;
            // The LBA is captured entering SETUP so it leads the strobe by a cycle.
            if (state_q == IDLE && pick_valid) begin
                sdc_lba_q <= lba_q[pick_winner];
            end
            if (state_q == SETUP) begin
                done_flag_q <= 1'b0;
            end else if (sdc_done) begin
                done_flag_q <= 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_q[i] && (req_rd[i] || req_wr[i])) begin
                    pend_q[i] <= 1'b1;
                    dir_q[i]  <= !req_rd[i];
                    lba_q[i]  <= req_lba[i*32 +: 32];
                end else if (state_q == ISSUE && owner_q == OWNER_W'(i)) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    assign sdc_rd       = (state_q == ISSUE && !dir_q[owner_q]) ? owner_oh : '0;
    assign sdc_wr       = (state_q == ISSUE &&  dir_q[owner_q]) ? owner_oh : '0;
    assign req_ack      = (sdc_busy && (state_q == WAIT || state_q == XFER)) ? owner_oh : '0;
    assign req_done     = req_done_q;
    assign req_err      = req_err_q;
    assign sdc_lba      = sdc_lba_q;
    assign sdc_data_out = req_dout[owner_q*8 +: 8];
    assign owner        = owner_q;

endmodule
